tb_status_periph: RTL and testbench

TB_STATUS_PERIPH -- requirements
Module: tb_status_periph

---
 rtl/tb_status_periph.sv | 144 ++++++++++++++
 tb/tb_tb_status_periph.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_status_periph.sv
// Testbench status peripheral: a stdout character FIFO plus pass/fail and exit-code
// registers, reached over a req/gnt/rvalid core data bus with one-cycle responses.
module tb_status_periph #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] PRINT_ADDR  = 32'h1000_0000,
    parameter logic [31:0] STATUS_ADDR = 32'h2000_0000,
    parameter logic [31:0] EXIT_ADDR   = 32'h2000_0004
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int unsigned      PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W         = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT      = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      PASS_CODE     = 32'd123456789;
    localparam logic [31:0]      FAIL_CODE     = 32'd1;
    localparam logic [31:0]      UNMAPPED_DATA = 32'hDEAD_BEEF;

    logic [31:0]      word_addr;
    logic             sel_print, sel_status, sel_exit;
    logic             fifo_full, pop, push;
    logic             grant, wr_grant, rd_grant;
    logic             unused_bits;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             passed_q, passed_d;
    logic             failed_q, failed_d;
    logic             exit_valid_q, exit_valid_d;
    logic [31:0]      exit_value_q, exit_value_d;
    logic             passed_seen_q, passed_seen_d;
    logic             failed_seen_q, failed_seen_d;

    // Byte-lane offset bits never select a different register.
    assign word_addr   = {data_addr_i[31:2], 2'b00};
    assign unused_bits = ^{data_addr_i[1:0], data_be_i[3:1]};
    assign sel_print   = (word_addr == PRINT_ADDR);
    assign sel_status  = (word_addr == STATUS_ADDR);
    assign sel_exit    = (word_addr == EXIT_ADDR);

    assign char_valid_o = (count_q != '0);
    assign char_o       = fifo_mem[rd_ptr_q];
    assign fifo_full    = (count_q == FULL_CNT);
    assign pop          = char_valid_o && char_ready_i;

    // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
    assign grant    = data_req_i && !(data_we_i && sel_print && fifo_full && !pop);
    assign wr_grant = grant && data_we_i;
    assign rd_grant = grant && !data_we_i;
    assign push     = wr_grant && sel_print && data_be_i[0];

    assign data_gnt_o     = grant;
    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rvalid_d = grant;
        rdata_d  = '0;
        if (rd_grant) begin
            if (sel_print)       rdata_d = 32'(count_q);
            else if (sel_status) rdata_d = {30'b0, failed_seen_q, passed_seen_q};
            else if (sel_exit)   rdata_d = exit_value_q;
            else                 rdata_d = UNMAPPED_DATA;
        end
        passed_d      = wr_grant && sel_status && (data_wdata_i == PASS_CODE);
        failed_d      = wr_grant && sel_status && (data_wdata_i == FAIL_CODE);
        exit_valid_d  = wr_grant && sel_exit;
        exit_value_d  = exit_valid_d ? data_wdata_i : exit_value_q;
        passed_seen_d = passed_seen_q || passed_d;
        failed_seen_d = failed_seen_q || failed_d;
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            passed_q      <= 1'b0;
            failed_q      <= 1'b0;
            exit_valid_q  <= 1'b0;
            exit_value_q  <= '0;
            passed_seen_q <= 1'b0;
            failed_seen_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            passed_q      <= passed_d;
            failed_q      <= failed_d;
            exit_valid_q  <= exit_valid_d;
            exit_value_q  <= exit_value_d;
            passed_seen_q <= passed_seen_d;
            failed_seen_q <= failed_seen_d;
        end
    end

    // NOTE: the character storage is not reset; occupancy gates every use of its contents.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= data_wdata_i[7:0];
    end

endmodule

// File: tb/tb_tb_status_periph.sv
// Self-checking bench for tb_status_periph: directed scenarios plus a randomized run
// compared against a queue-based model of the peripheral's bus and FIFO behaviour.
module tb_tb_status_periph;
    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] PRINT_A  = 32'h1000_0000;
    localparam logic [31:0] STATUS_A = 32'h2000_0000;
    localparam logic [31:0] EXIT_A   = 32'h2000_0004;
    localparam logic [31:0] UNMAP_A  = 32'h3000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, ready = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0, wdata = '0;
    logic        gnt, rvalid, cvalid, passed, failed, exit_valid;
    logic [31:0] rdata, exit_value;
    logic [7:0]  ch;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    tb_status_periph #(.FIFO_DEPTH(DEPTH), .PRINT_ADDR(PRINT_A),
                       .STATUS_ADDR(STATUS_A), .EXIT_ADDR(EXIT_A)) dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata),
        .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
        .char_valid_o(cvalid), .char_o(ch), .char_ready_i(ready),
        .tests_passed_o(passed), .tests_failed_o(failed),
        .exit_valid_o(exit_valid), .exit_value_o(exit_value)
    );

    // Reference model: the FIFO is a queue of bytes, results are sticky flags.
    logic [7:0]  mq [$];
    bit          m_pseen, m_fseen, m_g, m_p;
    bit          m_rvalid, m_read, m_passed, m_failed, m_exit_valid;
    logic [31:0] m_exit_value, m_rdata, m_wa;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function bit m_pop();
        return ready && (mq.size() != 0);
    endfunction

    function bit m_gnt();
        if (!req) return 1'b0;
        if (we && word_of(addr) == PRINT_A && mq.size() == DEPTH && !m_pop()) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pseen = 0; m_fseen = 0; m_exit_value = '0;
            m_rvalid = 0; m_read = 0; m_rdata = '0;
            m_passed = 0; m_failed = 0; m_exit_valid = 0;
        end else begin
            m_g = m_gnt(); m_p = m_pop(); m_wa = word_of(addr);
            m_rvalid = m_g; m_read = m_g && !we; m_rdata = '0;
            m_passed = 0; m_failed = 0; m_exit_valid = 0;
            if (m_read) begin
                if (m_wa == PRINT_A)       m_rdata = 32'(mq.size());
                else if (m_wa == STATUS_A) m_rdata = {30'b0, m_fseen, m_pseen};
                else if (m_wa == EXIT_A)   m_rdata = m_exit_value;
                else                       m_rdata = 32'hDEAD_BEEF;
            end
            if (m_p) void'(mq.pop_front());
            if (m_g && we) begin
                if (m_wa == PRINT_A && be[0]) mq.push_back(wdata[7:0]);
                if (m_wa == STATUS_A && wdata == 32'd123456789) begin m_passed = 1; m_pseen = 1; end
                if (m_wa == STATUS_A && wdata == 32'd1) begin m_failed = 1; m_fseen = 1; end
                if (m_wa == EXIT_A) begin m_exit_valid = 1; m_exit_value = wdata; end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid); end
        n_checks++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL reset_char_valid got=%0b exp=0", cvalid); end
        n_checks++; if ({passed, failed, exit_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%03b exp=000", {passed, failed, exit_valid}); end
        n_checks++; if (exit_value !== 32'h0) begin n_fail++; $display("FAIL reset_exit_value got=%h exp=0", exit_value); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        #1;
        n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_idle_gnt got=%0b exp=0", gnt); end
    endtask

    task automatic test_print_order();
        logic [7:0] exp_ch;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_ch = 8'h41 + 8'(i);
            drive(1'b1, 1'b1, 4'b0001, PRINT_A, {24'h0, exp_ch});
            #1;
            n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL print_gnt[%0d] got=%0b exp=1", i, gnt); end
            tick();
            n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL print_rvalid[%0d] got=%0b exp=1", i, rvalid); end
            n_checks++; if (cvalid !== 1'b1 || ch !== exp_ch) begin n_fail++; $display("FAIL print_char[%0d] got=%0b/%h exp=1/%h", i, cvalid, ch, exp_ch); end
        end
        idle(); tick();
        n_checks++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL print_drained got=%0b exp=0", cvalid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_ch;
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 4'b0001, PRINT_A, 32'h10 + 32'(i));
            #1;
            n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL fill_gnt[%0d] got=%0b exp=1", i, gnt); end
            tick();
        end
        drive(1'b1, 1'b1, 4'b0001, PRINT_A, 32'h18);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL full_stall_gnt[%0d] got=%0b exp=0", c, gnt); end
            tick();
            n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL full_stall_rvalid[%0d] got=%0b exp=0", c, rvalid); end
        end
        ready = 1'b1;
        #1;
        n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL full_pop_gnt got=%0b exp=1", gnt); end
        tick();
        n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL full_pop_rvalid got=%0b exp=1", rvalid); end
        ready = 1'b0;
        drive(1'b1, 1'b0, 4'hF, PRINT_A, 32'h0);
        tick();
        n_checks++; if (rvalid !== 1'b1 || rdata !== 32'd8) begin n_fail++; $display("FAIL full_occupancy got=%0b/%0d exp=1/8", rvalid, rdata); end
        idle(); ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            exp_ch = 8'h11 + 8'(j);
            n_checks++; if (cvalid !== 1'b1 || ch !== exp_ch) begin n_fail++; $display("FAIL drain_char[%0d] got=%0b/%h exp=1/%h", j, cvalid, ch, exp_ch); end
            tick();
        end
        n_checks++; if (cvalid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0b exp=0", cvalid); end
    endtask

    task automatic test_status();
        drive(1'b1, 1'b1, 4'hF, STATUS_A, 32'd123456789);
        tick();
        n_checks++; if ({rvalid, passed, failed} !== 3'b110) begin n_fail++; $display("FAIL status_pass_pulse got=%03b exp=110", {rvalid, passed, failed}); end
        drive(1'b1, 1'b0, 4'hF, STATUS_A, 32'h0);
        tick();
        n_checks++; if (passed !== 1'b0) begin n_fail++; $display("FAIL status_pass_one_cycle got=%0b exp=0", passed); end
        n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h1) begin n_fail++; $display("FAIL status_read_pass got=%0b/%h exp=1/1", rvalid, rdata); end
        drive(1'b1, 1'b1, 4'hF, STATUS_A, 32'd1);
        tick();
        n_checks++; if ({passed, failed} !== 2'b01) begin n_fail++; $display("FAIL status_fail_pulse got=%02b exp=01", {passed, failed}); end
        drive(1'b1, 1'b1, 4'hF, STATUS_A, 32'd7);
        tick();
        n_checks++; if ({passed, failed} !== 2'b00) begin n_fail++; $display("FAIL status_other_value got=%02b exp=00", {passed, failed}); end
        drive(1'b1, 1'b0, 4'hF, STATUS_A, 32'h0);
        tick();
        n_checks++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL status_read_sticky got=%h exp=3", rdata); end
        idle(); tick();
    endtask

    task automatic test_exit();
        drive(1'b1, 1'b1, 4'hF, EXIT_A, 32'h0000_0005);
        tick();
        n_checks++; if (exit_valid !== 1'b1 || exit_value !== 32'd5) begin n_fail++; $display("FAIL exit_pulse got=%0b/%h exp=1/5", exit_valid, exit_value); end
        drive(1'b1, 1'b0, 4'hF, EXIT_A, 32'h0);
        tick();
        n_checks++; if (exit_valid !== 1'b0) begin n_fail++; $display("FAIL exit_one_cycle got=%0b exp=0", exit_valid); end
        n_checks++; if (rvalid !== 1'b1 || rdata !== 32'd5) begin n_fail++; $display("FAIL exit_read got=%0b/%h exp=1/5", rvalid, rdata); end
        idle(); tick();
        n_checks++; if (exit_value !== 32'd5) begin n_fail++; $display("FAIL exit_hold got=%h exp=5", exit_value); end
    endtask

    task automatic test_unmapped();
        drive(1'b1, 1'b0, 4'hF, UNMAP_A, 32'h0);
        tick();
        n_checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unmapped_read got=%0b/%h exp=1/deadbeef", rvalid, rdata); end
        drive(1'b1, 1'b1, 4'hF, UNMAP_A, 32'd123456789);
        tick();
        n_checks++; if ({rvalid, passed, exit_valid} !== 3'b100) begin n_fail++; $display("FAIL unmapped_write got=%03b exp=100", {rvalid, passed, exit_valid}); end
        ready = 1'b0;
        drive(1'b1, 1'b1, 4'b1110, PRINT_A, 32'h5A);
        tick();
        drive(1'b1, 1'b0, 4'hF, PRINT_A, 32'h0);
        tick();
        n_checks++; if (rdata !== 32'h0 || cvalid !== 1'b0) begin n_fail++; $display("FAIL be0_discard got=%h/%0b exp=0/0", rdata, cvalid); end
        drive(1'b1, 1'b0, 4'hF, STATUS_A, 32'h0);
        tick();
        n_checks++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL unmapped_no_change got=%h exp=3", rdata); end
        drive(1'b1, 1'b0, 4'hF, EXIT_A + 32'd2, 32'h0);
        tick();
        n_checks++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL offset_addr_read got=%h exp=5", rdata); end
        idle(); tick();
        n_checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL idle_response got=%0b/%h exp=0/0", rvalid, rdata); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 4'b0001, PRINT_A, 32'h61 + 32'(i));
            tick();
        end
        drive(1'b1, 1'b0, 4'hF, STATUS_A, 32'h0);
        rst = 1'b1;
        tick();
        n_checks++; if (rvalid !== 1'b0 || cvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_drop got=%0b/%0b exp=0/0", rvalid, cvalid); end
        rst = 1'b0; idle();
        tick();
        n_checks++; if (rvalid !== 1'b0 || exit_value !== 32'h0) begin n_fail++; $display("FAIL midreset_after got=%0b/%h exp=0/0", rvalid, exit_value); end
        drive(1'b1, 1'b0, 4'hF, PRINT_A, 32'h0);
        tick();
        n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_occupancy got=%0b/%0d exp=1/0", rvalid, rdata); end
        drive(1'b1, 1'b0, 4'hF, STATUS_A, 32'h0);
        tick();
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_sticky_clear got=%h exp=0", rdata); end
        idle(); tick();
    endtask

    task automatic test_random();
        logic [31:0] amap [5] = '{PRINT_A, STATUS_A, EXIT_A, UNMAP_A, PRINT_A + 32'd3};
        int unsigned k;
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            ready = ($urandom_range(0, 9) < 4);
            k     = $urandom_range(0, 6);
            if (k > 4) k = 0;
            case ($urandom_range(0, 7))
                0:       wdata = 32'd123456789;
                1:       wdata = 32'd1;
                default: wdata = $urandom;
            endcase
            req = ($urandom_range(0, 3) != 0); we = ($urandom_range(0, 2) != 0);
            be = 4'($urandom); addr = amap[k];
            #1;
            n_checks++; if (gnt !== m_gnt()) begin n_fail++; $display("FAIL rnd_gnt[%0d] got=%0b exp=%0b", n, gnt, m_gnt()); end
            tick();
            n_checks++; if (rvalid !== m_rvalid) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got=%0b exp=%0b", n, rvalid, m_rvalid); end
            if (m_read) begin
                n_checks++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, rdata, m_rdata); end
            end
            if (!m_rvalid) begin
                n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rnd_rdata_idle[%0d] got=%h exp=0", n, rdata); end
            end
            n_checks++; if ({passed, failed, exit_valid} !== {m_passed, m_failed, m_exit_valid}) begin n_fail++; $display("FAIL rnd_pulses[%0d] got=%03b exp=%03b", n, {passed, failed, exit_valid}, {m_passed, m_failed, m_exit_valid}); end
            n_checks++; if (exit_value !== m_exit_value) begin n_fail++; $display("FAIL rnd_exit_value[%0d] got=%h exp=%h", n, exit_value, m_exit_value); end
            n_checks++; if (cvalid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_char_valid[%0d] got=%0b exp=%0d", n, cvalid, mq.size()); end
            if (mq.size() != 0) begin
                n_checks++; if (ch !== mq[0]) begin n_fail++; $display("FAIL rnd_char[%0d] got=%h exp=%h", n, ch, mq[0]); end
            end
        end
        rst = 1'b0; idle(); tick();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_print_order();
        test_backpressure();
        test_status();
        test_exit();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
